// File: rtl/stomp_event_generator.sv
`timescale 1ns/1ps
// stomp_event_generator: per-frame stomp detection between two characters,
//   producing one-frame registered event pulses and per-victim invulnerability cooldowns.
// Latency: one frame_clk edge from sampled positions to character*_stepped / char*_invuln.
// Backpressure: none; events are pulses the game FSM must consume in the frame they appear.
//
// Ports:
//   frame_clk            one rising edge per video frame
//   Reset                asynchronous, active-high; clears pulses and cooldowns
//   game_state           0 IDLE, 1 PLAYING, 2 GAME_OVER, 3 unused (non-PLAYING)
//   char1_x/y, char2_x/y top-left pixel of each sprite, y grows downward
//   char1/2_falling      character is moving down this frame
//   character1_stepped   pulse: character 1 landed on character 2
//   character2_stepped   pulse: character 2 landed on character 1
//   char1/2_invuln       victim cooldown is running (sprite blink)
module stomp_event_generator #(
  parameter int CHAR_W          = 32,
  parameter int CHAR_H          = 32,
  parameter int STOMP_BAND      = 8,
  parameter int COOLDOWN_FRAMES = 60,
  // COOLDOWN_FRAMES must be below 2**CD_W or the load value truncates.
  parameter int CD_W            = 7
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [1:0] game_state,
  input  logic [9:0] char1_x,
  input  logic [9:0] char1_y,
  input  logic [9:0] char2_x,
  input  logic [9:0] char2_y,
  input  logic       char1_falling,
  input  logic       char2_falling,
  output logic       character1_stepped,
  output logic       character2_stepped,
  output logic       char1_invuln,
  output logic       char2_invuln
);

  localparam logic [1:0]      ST_PLAYING = 2'd1;
  localparam logic [10:0]     W_EXT      = 11'(CHAR_W);
  localparam logic [10:0]     H_EXT      = 11'(CHAR_H);
  localparam logic [10:0]     BAND_EXT   = 11'(STOMP_BAND);
  localparam logic [CD_W-1:0] CD_LOAD    = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE     = CD_W'(1);

  // One extra bit of headroom so position + size never wraps.
  logic [10:0] x1, y1, x2, y2;
  logic [10:0] x1_right, x2_right;
  logic [10:0] y1_bottom, y2_bottom;
  logic [10:0] y1_band, y2_band;

  assign x1 = {1'b0, char1_x};
  assign y1 = {1'b0, char1_y};
  assign x2 = {1'b0, char2_x};
  assign y2 = {1'b0, char2_y};

  assign x1_right  = x1 + W_EXT;
  assign x2_right  = x2 + W_EXT;
  assign y1_bottom = y1 + H_EXT;
  assign y2_bottom = y2 + H_EXT;
  assign y1_band   = y1 + BAND_EXT;
  assign y2_band   = y2 + BAND_EXT;

  logic h_ovl;
  logic feet1_in_head2;
  logic feet2_in_head1;
  logic s12, s21;
  logic tie;
  logic playing;
  logic fire12, fire21;

  // Strict inequalities: sprites whose sides merely touch do not overlap.
  assign h_ovl = (x1 < x2_right) && (x2 < x1_right);

  // The attacker's bottom edge must land inside the band just below the victim's top edge.
  assign feet1_in_head2 = (y1_bottom >= y2) && (y1_bottom < y2_band);
  assign feet2_in_head1 = (y2_bottom >= y1) && (y2_bottom < y1_band);

  assign s12 = char1_falling && h_ovl && feet1_in_head2;
  assign s21 = char2_falling && h_ovl && feet2_in_head1;

  // A mutual stomp is ambiguous, so it is ignored entirely (no events, cooldowns frozen).
  assign tie     = s12 && s21;
  assign playing = (game_state == ST_PLAYING);

  logic [CD_W-1:0] cd1, cd2;
  logic [CD_W-1:0] cd1_nxt, cd2_nxt;

  // Each direction is gated only by the victim's own cooldown.
  assign fire12 = playing && s12 && !s21 && (cd2 == '0);
  assign fire21 = playing && s21 && !s12 && (cd1 == '0);

  // Cooldown next state. Leaving PLAYING clears both so a new match starts clean.
  always_comb begin
    cd1_nxt = cd1;
    cd2_nxt = cd2;
    if (!playing) begin
      cd1_nxt = '0;
      cd2_nxt = '0;
    end else if (!tie) begin
      if (fire21) begin
        cd1_nxt = CD_LOAD;
      end else if (cd1 != '0) begin
        cd1_nxt = cd1 - CD_ONE;
      end

      if (fire12) begin
        cd2_nxt = CD_LOAD;
      end else if (cd2 != '0) begin
        cd2_nxt = cd2 - CD_ONE;
      end
    end
  end

  // Loading the cooldown on the firing edge is what keeps each pulse to a single frame.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cd1                <= '0;
      cd2                <= '0;
      character1_stepped <= 1'b0;
      character2_stepped <= 1'b0;
    end else begin
      cd1                <= cd1_nxt;
      cd2                <= cd2_nxt;
      character1_stepped <= fire12;
      character2_stepped <= fire21;
    end
  end

  assign char1_invuln = (cd1 != '0);
  assign char2_invuln = (cd2 != '0);

endmodule

// File: tb/tb_stomp_event_generator.sv
`timescale 1ns/1ps
module tb_stomp_event_generator;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int B  = 8;
  localparam int CD = 60;

  logic       frame_clk;
  logic       Reset;
  logic [1:0] game_state;
  logic [9:0] char1_x, char1_y, char2_x, char2_y;
  logic       char1_falling, char2_falling;
  logic       character1_stepped, character2_stepped;
  logic       char1_invuln, char2_invuln;

  // Second instance with a band taller than the sprite, the only geometry where a mutual stomp exists.
  logic       t_stp1, t_stp2, t_inv1, t_inv2;

  int checks   = 0;
  int failures = 0;

  stomp_event_generator dut (
    .frame_clk          (frame_clk),
    .Reset              (Reset),
    .game_state         (game_state),
    .char1_x            (char1_x),
    .char1_y            (char1_y),
    .char2_x            (char2_x),
    .char2_y            (char2_y),
    .char1_falling      (char1_falling),
    .char2_falling      (char2_falling),
    .character1_stepped (character1_stepped),
    .character2_stepped (character2_stepped),
    .char1_invuln       (char1_invuln),
    .char2_invuln       (char2_invuln)
  );

  stomp_event_generator #(.CHAR_H(4), .STOMP_BAND(8)) dut_tall_band (
    .frame_clk          (frame_clk),
    .Reset              (Reset),
    .game_state         (game_state),
    .char1_x            (char1_x),
    .char1_y            (char1_y),
    .char2_x            (char2_x),
    .char2_y            (char2_y),
    .char1_falling      (char1_falling),
    .char2_falling      (char2_falling),
    .character1_stepped (t_stp1),
    .character2_stepped (t_stp2),
    .char1_invuln       (t_inv1),
    .char2_invuln       (t_inv2)
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input int gs, input int x1, input int y1, input int x2, input int y2,
                        input bit f1, input bit f2);
    game_state    = 2'(gs);
    char1_x       = 10'(x1);
    char1_y       = 10'(y1);
    char2_x       = 10'(x2);
    char2_y       = 10'(y2);
    char1_falling = f1;
    char2_falling = f2;
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge frame_clk);
    #1;
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  // Reference model: cooldowns as plain integer frame counts.
  int m_cd1, m_cd2;
  bit m_e1, m_e2;

  task automatic model_step();
    int x1, y1, x2, y2;
    bit ovl, a12, a21, play;
    x1 = int'(char1_x); y1 = int'(char1_y);
    x2 = int'(char2_x); y2 = int'(char2_y);
    ovl  = (x1 < x2 + W) && (x2 < x1 + W);
    a12  = char1_falling && ovl && (y1 + H >= y2) && (y1 + H < y2 + B);
    a21  = char2_falling && ovl && (y2 + H >= y1) && (y2 + H < y1 + B);
    play = (game_state == 2'd1);
    m_e1 = play && a12 && !a21 && (m_cd2 == 0);
    m_e2 = play && a21 && !a12 && (m_cd1 == 0);
    if (!play) begin
      m_cd1 = 0;
      m_cd2 = 0;
    end else if (!(a12 && a21)) begin
      m_cd1 = m_e2 ? CD : ((m_cd1 > 0) ? m_cd1 - 1 : 0);
      m_cd2 = m_e1 ? CD : ((m_cd2 > 0) ? m_cd2 - 1 : 0);
    end
  endtask

  typedef struct {
    string name;
    int    gs;
    int    x1, y1, x2, y2;
    bit    f1, f2;
    bit    e1, e2, i1, i2;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int hits[$];
    int cnt;
    Reset = 1'b1;
    set_in(1, 0, 0, 500, 500, 0, 0);

    vecs[0]  = '{"single_stomp",      1, 100, 60, 110, 90, 1, 0, 1, 0, 0, 1};
    vecs[1]  = '{"touch_right_edge",  1, 142, 60, 110, 90, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{"overlap_1px_right", 1, 141, 60, 110, 90, 1, 0, 1, 0, 0, 1};
    vecs[3]  = '{"touch_left_edge",   1, 100, 60, 132, 90, 1, 0, 0, 0, 0, 0};
    vecs[4]  = '{"band_end_excl",     1, 100, 66, 110, 90, 1, 0, 0, 0, 0, 0};
    vecs[5]  = '{"band_last_row",     1, 100, 65, 110, 90, 1, 0, 1, 0, 0, 1};
    vecs[6]  = '{"above_head",        1, 100, 57, 110, 90, 1, 0, 0, 0, 0, 0};
    vecs[7]  = '{"not_falling",       1, 100, 60, 110, 90, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{"char2_stomps",      1, 110, 90, 100, 60, 0, 1, 0, 1, 1, 0};
    vecs[9]  = '{"game_over",         2, 100, 60, 110, 90, 1, 0, 0, 0, 0, 0};
    vecs[10] = '{"idle",              0, 110, 90, 100, 60, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{"state3",            3, 100, 60, 110, 90, 1, 0, 0, 0, 0, 0};

    // Reset state, asserted from time zero.
    #3;
    chk("reset_stp1", 32'(character1_stepped), 0);
    chk("reset_stp2", 32'(character2_stepped), 0);
    chk("reset_inv1", 32'(char1_invuln), 0);
    chk("reset_inv2", 32'(char2_invuln), 0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      do_reset();
      set_in(vecs[i].gs, vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2, vecs[i].f1, vecs[i].f2);
      tick();
      chk({vecs[i].name, "_stp1"}, 32'(character1_stepped), 32'(vecs[i].e1));
      chk({vecs[i].name, "_stp2"}, 32'(character2_stepped), 32'(vecs[i].e2));
      chk({vecs[i].name, "_inv1"}, 32'(char1_invuln), 32'(vecs[i].i1));
      chk({vecs[i].name, "_inv2"}, 32'(char2_invuln), 32'(vecs[i].i2));
    end

    // Single stomp: one pulse, then exactly 60 invulnerable frames.
    do_reset();
    set_in(1, 100, 60, 110, 90, 1, 0);
    cnt = 0;
    hits.delete();
    for (int f = 0; f < 70; f++) begin
      tick();
      if (f == 0) char1_falling = 1'b0;
      if (character1_stepped) hits.push_back(f);
      if (char2_invuln) cnt++;
    end
    chk("single_pulse_count", 32'(hits.size()), 1);
    chk("single_invuln_frames", 32'(cnt), 60);

    // Held geometry re-fires every COOLDOWN+1 frames.
    do_reset();
    set_in(1, 100, 60, 110, 90, 1, 0);
    hits.delete();
    for (int f = 0; f < 130; f++) begin
      tick();
      if (character1_stepped) hits.push_back(f);
    end
    chk("camp_pulse_count", 32'(hits.size()), 3);
    if (hits.size() == 3) begin
      chk("camp_first", 32'(hits[0]), 0);
      chk("camp_second", 32'(hits[1]), 61);
      chk("camp_third", 32'(hits[2]), 122);
    end

    // Asynchronous reset with cd2 at 40, between edges.
    do_reset();
    set_in(1, 100, 60, 110, 90, 1, 0);
    tick();
    char1_falling = 1'b0;
    repeat (20) tick();
    chk("pre_reset_inv2", 32'(char2_invuln), 1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_reset_inv2", 32'(char2_invuln), 0);
    chk("async_reset_inv1", 32'(char1_invuln), 0);
    chk("async_reset_stp1", 32'(character1_stepped), 0);
    #1;
    Reset = 1'b0;

    // Independent cooldowns: cd2 = 30, character 2 stomps character 1.
    do_reset();
    set_in(1, 100, 60, 110, 90, 1, 0);
    tick();
    char1_falling = 1'b0;
    repeat (30) tick();
    set_in(1, 110, 90, 100, 60, 0, 1);
    tick();
    chk("indep_stp2", 32'(character2_stepped), 1);
    chk("indep_inv1", 32'(char1_invuln), 1);
    chk("indep_inv2", 32'(char2_invuln), 1);

    // Leaving PLAYING with cd1 = 20 clears invulnerability in one edge.
    do_reset();
    set_in(1, 110, 90, 100, 60, 0, 1);
    tick();
    char2_falling = 1'b0;
    repeat (40) tick();
    chk("pre_idle_inv1", 32'(char1_invuln), 1);
    game_state = 2'd0;
    tick();
    chk("idle_clears_inv1", 32'(char1_invuln), 0);

    // Mutual stomp on the tall-band instance: nothing fires.
    do_reset();
    set_in(1, 100, 100, 100, 100, 1, 1);
    cnt = 0;
    repeat (3) begin
      tick();
      if (t_stp1 || t_stp2 || t_inv1 || t_inv2) cnt++;
    end
    chk("tie_quiet_frames", 32'(cnt), 0);
    do_reset();
    set_in(1, 100, 96, 100, 100, 1, 1);
    tick();
    chk("tall_band_stp1", 32'(t_stp1), 1);
    chk("tall_band_stp2", 32'(t_stp2), 0);

    // Randomized segments against the reference model.
    do_reset();
    m_cd1 = 0;
    m_cd2 = 0;
    for (int seg = 0; seg < 60; seg++) begin
      int bx, by, dx, dy, len;
      bit swap;
      bx   = int'($urandom_range(100, 800));
      by   = int'($urandom_range(100, 800));
      dx   = int'($urandom_range(0, 80)) - 40;
      dy   = int'($urandom_range(0, 20)) - 10;
      swap = $urandom_range(0, 1) == 1;
      len  = int'($urandom_range(1, 70));
      if (swap) set_in(1, bx, by, bx + dx, by - H + dy, 0, 0);
      else      set_in(1, bx + dx, by - H + dy, bx, by, 0, 0);
      if ($urandom_range(0, 9) == 0) game_state = 2'($urandom_range(0, 3));
      for (int f = 0; f < len; f++) begin
        char1_falling = $urandom_range(0, 9) < 7;
        char2_falling = $urandom_range(0, 9) < 7;
        model_step();
        tick();
        chk("rand_stp1", 32'(character1_stepped), 32'(m_e1));
        chk("rand_stp2", 32'(character2_stepped), 32'(m_e2));
        chk("rand_inv1", 32'(char1_invuln), 32'(m_cd1 != 0));
        chk("rand_inv2", 32'(char2_invuln), 32'(m_cd2 != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
